// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction-memory loader: opcodes, FSM encoding, header marker.
package instr_mem_loader_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_WORD, S_CHECK, S_DONE, S_ERR
  } state_t;

  // True when the decode path understands this opcode.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW: op_supported = 1'b1;
      default:                                op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_asm.sv
// Byte-to-word assembler: big-endian shift register, byte index and running XOR checksum.
module loader_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_done,
  output logic [7:0]  chk
);

  logic [31:0] word;
  logic [1:0]  idx;

  // The completed word is visible combinationally on the 4th byte so the top can register it.
  assign word_next = {word[23:0], byte_in};
  assign word_done = byte_en && (idx == 2'd3);

  // Shift in each word byte, advance the index and fold it into the checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
      chk  <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
      chk  <= '0;
    end else if (byte_en) begin
      word <= word_next;
      idx  <= idx + 2'd1;
      chk  <= chk ^ byte_in;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// UART-fed instruction memory loader: frame FSM, write address, idle timeout and opcode audit.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter bit         HALT_AT_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        bad_op_cnt
);

  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);

  state_t      state, state_n;
  logic        start, latch_n, asm_en, pass, fail, active, timeout;
  logic [7:0]  words_left;
  logic [19:0] timer;
  logic [31:0] word_next;
  logic        word_done;
  logic [7:0]  chk;

  loader_word_asm u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .byte_en   (asm_en),
    .byte_in   (rx_data),
    .word_next (word_next),
    .word_done (word_done),
    .chk       (chk)
  );

  assign active  = (state == S_COUNT) || (state == S_WORD) || (state == S_CHECK);
  assign timeout = active && !rx_done && (timer == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and per-byte strobes; the header only matters outside a load.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    latch_n = 1'b0;
    asm_en  = 1'b0;
    pass    = 1'b0;
    fail    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (rx_done && rx_data == HDR_BYTE) begin
          start   = 1'b1;
          state_n = S_COUNT;
        end
      end
      S_COUNT: begin
        if (rx_done) begin
          latch_n = 1'b1;
          state_n = (rx_data == 8'd0) ? S_CHECK : S_WORD;
        end
      end
      S_WORD: begin
        if (rx_done) begin
          asm_en = 1'b1;
          if (word_done && words_left == 8'd1) state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rx_done) begin
          if (rx_data == chk) begin
            pass    = 1'b1;
            state_n = S_DONE;
          end else begin
            fail    = 1'b1;
            state_n = S_ERR;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (timeout) begin
      fail    = 1'b1;
      state_n = S_ERR;
    end
  end

  // Memory write port: pulse one cycle after the 4th byte, address steps after the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_addr  <= '0;
    end else begin
      mem_we <= word_done;
      if (word_done) mem_wdata <= word_next;
      if (start)       mem_addr <= '0;
      else if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

  // Remaining word count for the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         words_left <= '0;
    else if (latch_n)   words_left <= rx_data;
    else if (word_done) words_left <= words_left - 8'd1;
  end

  // Idle timer: cleared by every byte, counts only while a load is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 timer <= '0;
    else if (!active || rx_done) timer <= '0;
    else                        timer <= timer + 20'd1;
  end

  // Status flags and the saturating unsupported-opcode counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_halt   <= HALT_AT_RST;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      bad_op_cnt <= '0;
    end else begin
      if (start) begin
        cpu_halt   <= 1'b1;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
        bad_op_cnt <= '0;
      end
      if (pass) begin
        load_done <= 1'b1;
        cpu_halt  <= 1'b0;
      end
      if (fail) load_err <= 1'b1;
      if (word_done && !op_supported(word_next[31:26]) && bad_op_cnt != 8'hFF)
        bad_op_cnt <= bad_op_cnt + 8'd1;
    end
  end

endmodule
